// File: rtl/result_sel_stage.sv
// EX->MEM writeback-result selector: picks one of NSRC unit results by select code,
// waits on multi-cycle sources, and holds the result under a valid/ready handshake.
module result_sel_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       in_sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_ready,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  output logic                  out_err,
  output logic [CNTW-1:0]       wait_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_t;

  state_t              r_state, w_next;
  logic [SELW-1:0]     r_wsel;
  logic [WIDTH-1:0]    r_data;
  logic [SELW-1:0]     r_sel;
  logic                r_err;
  logic [CNTW-1:0]     r_cnt;

  logic                w_sel_ok;
  logic                w_new_rdy;
  logic [WIDTH-1:0]    w_new_data;
  logic                w_wait_rdy;
  logic [WIDTH-1:0]    w_wait_data;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_load_new;
  logic                w_load_wait;

  // Codes beyond NSRC have no source; extend by one bit so the compare is never trivial.
  assign w_sel_ok = ({1'b0, in_sel} < (SELW+1)'(NSRC));

  // Two independent muxes: one for the incoming request, one for the latched WAIT select.
  always_comb begin
    w_new_rdy   = 1'b0;
    w_new_data  = '0;
    w_wait_rdy  = 1'b0;
    w_wait_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        w_new_rdy  = src_ready[k];
        w_new_data = src_data[k*WIDTH +: WIDTH];
      end
      if (r_wsel == SELW'(k)) begin
        w_wait_rdy  = src_ready[k];
        w_wait_data = src_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  // Next-state logic; flush wins over everything except reset
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) w_next = (!w_sel_ok || w_new_rdy) ? S_FULL : S_WAIT;
        end
        S_WAIT: begin
          if (w_wait_rdy) w_next = S_FULL;
        end
        S_FULL: begin
          if (w_accept)       w_next = (!w_sel_ok || w_new_rdy) ? S_FULL : S_WAIT;
          else if (out_ready) w_next = S_EMPTY;
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    w_in_ready  = !flush && ((r_state == S_EMPTY) || ((r_state == S_FULL) && out_ready));
    w_accept    = in_valid && w_in_ready;
    w_load_new  = w_accept && (!w_sel_ok || w_new_rdy);
    w_load_wait = (r_state == S_WAIT) && !flush && w_wait_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wsel <= '0;
    end else if (w_accept && w_sel_ok && !w_new_rdy) begin
      r_wsel <= in_sel;
    end
  end

  // Output register only moves on a load; flush leaves the last values in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_sel  <= '0;
      r_err  <= 1'b0;
    end else if (w_load_new) begin
      r_data <= w_sel_ok ? w_new_data : '0;
      r_sel  <= in_sel;
      r_err  <= !w_sel_ok;
    end else if (w_load_wait) begin
      r_data <= w_wait_data;
      r_sel  <= r_wsel;
      r_err  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_err   = r_err;
  assign wait_cnt  = r_cnt;

endmodule

// File: tb/tb_result_sel_stage.sv
// Bench for result_sel_stage: default build plus an NSRC=3/CNTW=4 build sharing the
// same stimulus, both checked every cycle against a transaction-level model.
module tb_result_sel_stage;

  logic         clk = 1'b0;
  logic         rst, in_valid, flush, out_ready;
  logic [1:0]   in_sel;
  logic [127:0] src_data;
  logic [3:0]   src_ready;

  logic         ir[2], ov[2], oerr[2];
  logic [31:0]  od[2];
  logic [1:0]   os[2];
  logic [15:0]  wc0;
  logic [3:0]   wc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  result_sel_stage #(.WIDTH(32), .NSRC(4), .SELW(2), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_sel(in_sel),
    .src_data(src_data), .src_ready(src_ready), .flush(flush), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_sel(os[0]), .out_err(oerr[0]),
    .wait_cnt(wc0)
  );

  result_sel_stage #(.WIDTH(32), .NSRC(3), .SELW(2), .CNTW(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_sel(in_sel),
    .src_data(src_data[95:0]), .src_ready(src_ready[2:0]), .flush(flush), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_sel(os[1]), .out_err(oerr[1]),
    .wait_cnt(wc1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a held result (mv), a pending request waiting on a source (mw/mws), a wait counter.
  bit          mv[2], mw[2], me[2];
  logic [31:0] md[2];
  logic [1:0]  ms[2], mws[2];
  int          mc[2];
  int          nsrc[2] = '{4, 3};
  int          cmax[2] = '{65535, 15};
  bit          minit = 1'b0;

  function automatic bit model_ready(int i);
    return !flush && ((!mv[i] && !mw[i]) || (mv[i] && out_ready));
  endfunction

  always @(posedge clk) begin
    bit take;
    for (int i = 0; i < 2; i++) begin
      take = in_valid && model_ready(i);
      if (rst) begin
        mv[i] = 0; mw[i] = 0; me[i] = 0; md[i] = 0; ms[i] = 0; mws[i] = 0; mc[i] = 0;
        minit = 1'b1;
      end else begin
        if (mw[i] && mc[i] < cmax[i]) mc[i] = mc[i] + 1;
        if (flush) begin
          mv[i] = 0;
          mw[i] = 0;
        end else if (mw[i]) begin
          if (src_ready[mws[i]]) begin
            md[i] = src_data[int'(mws[i])*32 +: 32];
            ms[i] = mws[i]; me[i] = 0; mv[i] = 1; mw[i] = 0;
          end
        end else begin
          if (mv[i] && out_ready) mv[i] = 0;
          if (take) begin
            if (int'(in_sel) >= nsrc[i]) begin
              md[i] = 0; me[i] = 1; ms[i] = in_sel; mv[i] = 1;
            end else if (src_ready[in_sel]) begin
              md[i] = src_data[int'(in_sel)*32 +: 32];
              me[i] = 0; ms[i] = in_sel; mv[i] = 1;
            end else begin
              mw[i] = 1; mws[i] = in_sel;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (minit) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("in_ready[%0d]", i),  ir[i],   model_ready(i));
        check($sformatf("out_valid[%0d]", i), ov[i],   mv[i]);
        check($sformatf("out_data[%0d]", i),  od[i],   md[i]);
        check($sformatf("out_sel[%0d]", i),   os[i],   ms[i]);
        check($sformatf("out_err[%0d]", i),   oerr[i], me[i]);
      end
      check("wait_cnt[0]", wc0, mc[0]);
      check("wait_cnt[1]", wc1, mc[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sel = 0; flush = 0; out_ready = 0;
    src_data = '0; src_ready = '1;
    tick(); tick();
    rst = 0;
    check("rst_valid", ov[0], 0);
    check("rst_data", od[0], 0);
    check("rst_in_ready", ir[0], 1);
    check("rst_wait_cnt", wc0, 0);

    // ready source: one-cycle latency
    src_data[31:0] = 32'h11111111; in_valid = 1; in_sel = 0;
    tick(); in_valid = 0;
    check("t1_valid", ov[0], 1);
    check("t1_data", od[0], 32'h11111111);
    check("t1_sel", os[0], 0);
    check("t1_err", oerr[0], 0);
    out_ready = 1;
    tick();

    // back-to-back, one per cycle; sel=3 is an error on the NSRC=3 build
    for (int k = 0; k < 4; k++) src_data[k*32 +: 32] = 32'hA0 + k;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sel = 2'(i);
      check("t2_in_ready", ir[0], 1);
      tick();
      check("t2_valid", ov[0], 1);
      check("t2_data", od[0], 32'hA0 + i);
    end
    check("t2_err3", oerr[1], 1);
    check("t2_data3", od[1], 0);
    check("t2_valid3", ov[1], 1);
    in_valid = 0;
    tick();
    check("t2_wait_cnt", wc0, 0);

    // waiting source: three WAIT cycles
    src_ready = 4'b1101; in_valid = 1; in_sel = 1;
    tick(); in_valid = 0;
    check("t3_in_ready", ir[0], 0);
    check("t3_valid", ov[0], 0);
    tick(); tick();
    src_data[63:32] = 32'hDEADBEEF; src_ready = 4'hF;
    tick();
    check("t3_data", od[0], 32'hDEADBEEF);
    check("t3_valid", ov[0], 1);
    check("t3_wait_cnt", wc0, 3);
    tick();

    // hold under backpressure while sources change
    out_ready = 0; src_data[95:64] = 32'h55; in_valid = 1; in_sel = 2;
    tick(); in_sel = 0;
    for (int i = 0; i < 5; i++) begin
      src_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("t4_hold_data", od[0], 32'h55);
      check("t4_hold_valid", ov[0], 1);
      check("t4_in_ready", ir[0], 0);
    end
    in_valid = 0; out_ready = 1;
    tick();
    check("t4_drained", ov[0], 0);
    tick();

    // flush in WAIT; the late source-ready must be ignored
    src_ready = 4'h0; in_valid = 1; in_sel = 2;
    tick(); in_valid = 0; flush = 1;
    check("t5_flush_in_ready", ir[0], 0);
    tick(); flush = 0;
    check("t5_valid", ov[0], 0);
    src_ready = 4'hF;
    tick();
    check("t5_late_ready", ov[0], 0);
    check("t5_data_kept", od[0], 32'h55);
    tick();

    // flush in FULL
    src_data[31:0] = 32'h77; in_valid = 1; in_sel = 0;
    tick(); in_valid = 0; flush = 1; out_ready = 1;
    check("t6_full", ov[0], 1);
    tick(); flush = 0;
    check("t6_valid", ov[0], 0);
    check("t6_data_kept", od[0], 32'h77);

    // long wait: 4-bit counter saturates at 15
    src_ready = 4'h0; in_valid = 1; in_sel = 1;
    tick(); in_valid = 0;
    repeat (20) tick();
    check("t7_wait_cnt", wc0, 24);
    check("t7_wait_sat", wc1, 15);

    // reset mid-WAIT
    rst = 1;
    tick(); rst = 0;
    check("t8_valid", ov[0], 0);
    check("t8_data", od[0], 0);
    check("t8_sel", os[0], 0);
    check("t8_wait_cnt", wc0, 0);
    check("t8_wait_cnt3", wc1, 0);
    check("t8_in_ready", ir[0], 1);
    src_ready = 4'hF;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_sel_stage.md
# result_sel_stage

Registered, parametrised writeback-result selector between the EX and MEM stages of the pipeline CPU. It picks one of `NSRC` execution-unit results by select code and holds it in an output pipeline register under a valid/ready handshake. It waits for multi-cycle sources (multiplier/divider Hi/Lo) that are not yet ready. It supports pipeline flush and counts the cycles lost waiting on sources.

## Interface

Parameters:
- `WIDTH`, 32, datapath width of every source and of the result.
- `NSRC`, 4, number of result sources (ALU=0, Hi=1, Lo=2, SHT=3 in the default build).
- `SELW`, 2, select width; must satisfy 2^`SELW` >= `NSRC`.
- `CNTW`, 16, width of the wait-cycle counter.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream request present this cycle.
- `in_ready` out 1: stage accepts a request this cycle.
- `in_sel` in `SELW`: source select of the request.
- `src_data` in `NSRC*WIDTH`: source k on bits [k*WIDTH +: WIDTH].
- `src_ready` in `NSRC`: bit k high means `src_data` source k holds a valid result this cycle.
- `flush` in 1: discard pending and held results.
- `out_valid` out 1: `out_data`/`out_sel`/`out_err` are valid.
- `out_ready` in 1: downstream consumes the output this cycle.
- `out_data` out `WIDTH`: selected result.
- `out_sel` out `SELW`: select code that produced `out_data`.
- `out_err` out 1: select code was >= `NSRC`.
- `wait_cnt` out `CNTW`: saturating count of cycles spent in WAIT.

## Operation

- FSM states: EMPTY (nothing held), WAIT (request accepted, source not ready), FULL (output register valid).
- Accept condition: `in_valid && in_ready`.
- `in_ready` = !`flush` && (state==EMPTY || (state==FULL && `out_ready`)). It is 0 in WAIT and combinational from state, `flush` and `out_ready`.
- On accept with sel < `NSRC` and `src_ready[sel]`=1:
  - `out_data` <= that source; `out_sel` <= sel; `out_err` <= 0.
  - Next state FULL.
- On accept with sel < `NSRC` and `src_ready[sel]`=0:
  - Latch sel internally; next state WAIT.
  - Output register unchanged, `out_valid`=0.
- On accept with sel >= `NSRC`:
  - `out_data` <= 0; `out_err` <= 1; `out_sel` <= sel.
  - Next state FULL; never waits.
- WAIT:
  - Each cycle, test `src_ready` of the latched sel.
  - When high, load `out_data` from that source, set `out_sel`, clear `out_err`, and go to FULL.
  - Otherwise stay in WAIT.
- FULL:
  - `out_valid`=1.
  - `out_ready`=1 with no accept in the same cycle: go to EMPTY.
  - `out_ready`=1 with an accept: apply the accept rules, so back-to-back transfers run at one per cycle.
  - `out_ready`=0: hold all outputs stable.
- `flush`:
  - Highest priority. Next state is EMPTY regardless of state, `out_ready` or `src_ready`.
  - The latched WAIT select is discarded.
  - `out_data`/`out_sel`/`out_err` keep their last values; only `out_valid` drops.
- `wait_cnt`:
  - +1 on every cycle in which state==WAIT, including the cycle a flush or the source-ready arrives.
  - Saturates at 2^`CNTW`-1.
  - Cleared only by `rst`.
- Multiple `src_ready` bits high: only the selected bit matters.

## Timing

- Reset (`rst`=1 at an edge):
  - State EMPTY; `out_valid`=0, `out_data`=0, `out_sel`=0, `out_err`=0, `wait_cnt`=0.
  - `in_ready` reads 1 in the first cycle after reset, if `flush`=0.
  - Reset overrides flush and any in-flight WAIT.
- Latency, ready source: accept at edge N; `out_valid`=1 in the cycle after edge N (1 cycle).
- Latency, waiting source: `out_valid`=1 the cycle after the edge where `src_ready[sel]` is first sampled high. Total latency is 1 + wait cycles.
- Throughput: 1 result/cycle while sources are ready and `out_ready`=1.
- Data is sampled only at the loading edge; later changes on `src_data` do not affect a held `out_data`.
- Flush and accept in the same cycle: no accept occurs (`in_ready`=0).
- Flush in FULL with `out_ready`=1: the transfer counts as consumed; next state EMPTY.

## Test plan

- Reset, then sel=0 with ALU=0x11111111 and all `src_ready`=1. Expect `out_valid` one cycle later, `out_data`=0x11111111, `out_sel`=0, `out_err`=0.
- Four back-to-back requests with sel=0,1,2,3, `out_ready`=1 and sources 0xA0..0xA3. Expect outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, `in_ready` constantly 1, `wait_cnt`=0.
- sel=1 with `src_ready[1]`=0 for 3 cycles, then Hi=0xDEADBEEF and ready. Expect `in_ready`=0 during WAIT, `out_data`=0xDEADBEEF one cycle after ready, `wait_cnt`=3.
- Hold FULL with `out_ready`=0 for 5 cycles while `src_data` changes. Expect outputs stable and `in_ready`=0, then a single transfer on `out_ready`=1.
- NSRC=3 build with sel=3. Expect `out_err`=1, `out_data`=0, no WAIT.
- Flush in WAIT and in FULL. Expect state EMPTY next cycle, `out_valid`=0, and the late `src_ready` ignored. Assert `rst` mid-WAIT: all outputs reset.
